// File: rtl/hl2link_pkg.sv
// Shared definitions for the hl2link send path: channel codes, word widths and packing helpers.
// Both the send arbiter and hl2link itself import this package.
package hl2link_pkg;

    localparam int CMD_DIBITS = 19;
    localparam int RX_DIBITS  = 13;
    localparam int TX_DIBITS  = 16;

    localparam int CMD_W  = 2 * CMD_DIBITS;
    localparam int RX_W   = 2 * RX_DIBITS;
    localparam int TX_W   = 2 * TX_DIBITS;
    localparam int LINK_W = CMD_W;

    // The channel select value is also the send_tuser code seen by hl2link
    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_CMD  = 2'b01,
        SEL_RX   = 2'b10,
        SEL_TX   = 2'b11
    } send_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_BUSY
    } send_state_e;

    function automatic logic [LINK_W-1:0] pack_rx(input logic [RX_W-1:0] d);
        return {d, {(LINK_W - RX_W){1'b0}}};
    endfunction

    function automatic logic [LINK_W-1:0] pack_tx(input logic [TX_W-1:0] d);
        return {d, {(LINK_W - TX_W){1'b0}}};
    endfunction

endpackage

// File: rtl/hl2link_send_arb_if.sv
// Stream bundle between the three word producers, the send arbiter and hl2link.
// The slave view is the arbiter; the master view is everything around it.
interface hl2link_send_arb_if;
    import hl2link_pkg::*;

    logic              cmd_tvalid;
    logic [CMD_W-1:0]  cmd_tdata;
    logic              cmd_tready;

    logic              rx_tvalid;
    logic [RX_W-1:0]   rx_tdata;
    logic              rx_tready;

    logic              tx_tvalid;
    logic [TX_W-1:0]   tx_tdata;
    logic              tx_tready;

    logic              send_tvalid;
    logic [LINK_W-1:0] send_tdata;
    logic [1:0]        send_tuser;
    logic              send_tready;
    logic              send_tdone;

    modport slave (
        input  cmd_tvalid, cmd_tdata, rx_tvalid, rx_tdata, tx_tvalid, tx_tdata,
        output cmd_tready, rx_tready, tx_tready,
        output send_tvalid, send_tdata, send_tuser,
        input  send_tready, send_tdone
    );

    modport master (
        output cmd_tvalid, cmd_tdata, rx_tvalid, rx_tdata, tx_tvalid, tx_tdata,
        input  cmd_tready, rx_tready, tx_tready,
        input  send_tvalid, send_tdata, send_tuser,
        output send_tready, send_tdone
    );

endinterface

// File: rtl/hl2link_arb_hold.sv
// One-entry holding register: captures a word while empty and keeps it until the arbiter
// releases it after hl2link accepts the word.
module hl2link_arb_hold #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         unload,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         ready
);

    assign ready = ~full;

    // Release only happens while full and load only while empty, so the two never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            dout <= '0;
        end else if (unload) begin
            full <= 1'b0;
        end else if (load && !full) begin
            full <= 1'b1;
            dout <= din;
        end
    end

endmodule

// File: rtl/hl2link_send_arb.sv
// Shares the hl2link send interface between command, RX and TX producers with aged priority,
// keeping exactly one word in flight and abandoning it cleanly on link drop or timeout.
module hl2link_send_arb
    import hl2link_pkg::*;
#(
    parameter int AGE_MAX = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              running,
    hl2link_send_arb_if.slave bus,
    output logic              abort,
    output logic [7:0]        lost_cnt
);

    localparam int AGE_W   = 4;
    localparam int TIMER_W = 7;
    localparam logic [AGE_W-1:0]   AGE_TOP    = AGE_W'(AGE_MAX);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    send_state_e        state, state_n;
    send_sel_e          sel_q, sel_n, pick;
    logic               tvalid_q, tvalid_n;
    logic [LINK_W-1:0]  tdata_q, tdata_n, pick_data;
    logic               abort_n;
    logic [7:0]         lost_n;
    logic [TIMER_W-1:0] timer_q, timer_n;
    logic [AGE_W-1:0]   rx_age, rx_age_n, tx_age, tx_age_n;

    logic               cmd_full, rx_full, tx_full;
    logic [CMD_W-1:0]   cmd_word;
    logic [RX_W-1:0]    rx_word;
    logic [TX_W-1:0]    tx_word;
    logic               cmd_ready, rx_ready, tx_ready;
    logic               accept;

    assign accept = (state == ST_OFFER) && bus.send_tready;

    hl2link_arb_hold #(.W(CMD_W)) u_cmd_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (bus.cmd_tvalid),
        .din    (bus.cmd_tdata),
        .unload (accept && (sel_q == SEL_CMD)),
        .dout   (cmd_word),
        .full   (cmd_full),
        .ready  (cmd_ready)
    );

    hl2link_arb_hold #(.W(RX_W)) u_rx_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (bus.rx_tvalid),
        .din    (bus.rx_tdata),
        .unload (accept && (sel_q == SEL_RX)),
        .dout   (rx_word),
        .full   (rx_full),
        .ready  (rx_ready)
    );

    hl2link_arb_hold #(.W(TX_W)) u_tx_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (bus.tx_tvalid),
        .din    (bus.tx_tdata),
        .unload (accept && (sel_q == SEL_TX)),
        .dout   (tx_word),
        .full   (tx_full),
        .ready  (tx_ready)
    );

    assign bus.cmd_tready  = cmd_ready;
    assign bus.rx_tready   = rx_ready;
    assign bus.tx_tready   = tx_ready;
    assign bus.send_tvalid = tvalid_q;
    assign bus.send_tdata  = tdata_q;
    assign bus.send_tuser  = sel_q;

    // A starved sample channel outranks even cmd; rx wins when both are starved
    always_comb begin
        pick = SEL_NONE;
        if (rx_full && rx_age == AGE_TOP) begin
            pick = SEL_RX;
        end else if (tx_full && tx_age == AGE_TOP) begin
            pick = SEL_TX;
        end else if (cmd_full) begin
            pick = SEL_CMD;
        end else if (tx_full) begin
            pick = SEL_TX;
        end else if (rx_full) begin
            pick = SEL_RX;
        end
    end

    always_comb begin
        case (pick)
            SEL_CMD: pick_data = cmd_word;
            SEL_RX:  pick_data = pack_rx(rx_word);
            SEL_TX:  pick_data = pack_tx(tx_word);
            default: pick_data = '0;
        endcase
    end

    always_comb begin
        state_n  = state;
        tvalid_n = tvalid_q;
        tdata_n  = tdata_q;
        sel_n    = sel_q;
        abort_n  = 1'b0;
        lost_n   = lost_cnt;
        timer_n  = timer_q;
        rx_age_n = rx_age;
        tx_age_n = tx_age;
        case (state)
            ST_IDLE: begin
                if (running && pick != SEL_NONE) begin
                    state_n  = ST_OFFER;
                    tvalid_n = 1'b1;
                    tdata_n  = pick_data;
                    sel_n    = pick;
                end
            end
            ST_OFFER: begin
                // An accept in the same cycle as a link drop still counts as accepted
                if (bus.send_tready) begin
                    state_n  = ST_BUSY;
                    tvalid_n = 1'b0;
                    timer_n  = '0;
                    if (sel_q == SEL_RX) begin
                        rx_age_n = '0;
                    end else if (rx_full && rx_age < AGE_TOP) begin
                        rx_age_n = rx_age + 1'b1;
                    end
                    if (sel_q == SEL_TX) begin
                        tx_age_n = '0;
                    end else if (tx_full && tx_age < AGE_TOP) begin
                        tx_age_n = tx_age + 1'b1;
                    end
                end else if (!running) begin
                    state_n  = ST_IDLE;
                    tvalid_n = 1'b0;
                    abort_n  = 1'b1;
                end
            end
            ST_BUSY: begin
                if (bus.send_tdone) begin
                    state_n = ST_IDLE;
                end else if (!running || timer_q == TIMER_LAST) begin
                    state_n = ST_IDLE;
                    abort_n = 1'b1;
                    if (lost_cnt != 8'hFF) begin
                        lost_n = lost_cnt + 8'd1;
                    end
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            sel_q    <= SEL_NONE;
            abort    <= 1'b0;
            lost_cnt <= 8'd0;
            timer_q  <= '0;
            rx_age   <= '0;
            tx_age   <= '0;
        end else begin
            tvalid_q <= tvalid_n;
            tdata_q  <= tdata_n;
            sel_q    <= sel_n;
            abort    <= abort_n;
            lost_cnt <= lost_n;
            timer_q  <= timer_n;
            rx_age   <= rx_age_n;
            tx_age   <= tx_age_n;
        end
    end

endmodule

// File: tb/tb_hl2link_send_arb.sv
// Bench for hl2link_send_arb: directed scenarios plus randomized traffic, all checked every
// cycle against a transaction-level model of holds, ages, offer and in-flight word.
module tb_hl2link_send_arb;
    import hl2link_pkg::*;

    localparam int AGE_MAX = 8;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       running;
    logic       abort;
    logic [7:0] lost_cnt;

    hl2link_send_arb_if bus();

    hl2link_send_arb #(.AGE_MAX(AGE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .running  (running),
        .bus      (bus),
        .abort    (abort),
        .lost_cnt (lost_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: channel 0 cmd, 1 rx, 2 tx; tuser code is channel+1
    bit          m_full[3];
    logic [37:0] m_word[3];
    int          m_age[3];
    bit          m_offer;
    int          m_ch;
    bit          m_flight;
    int          m_flight_t;
    bit          m_abort;
    int          m_lost;

    logic [1:0] obs_tags[$];
    int         rx_pos[$];
    bit         log_en = 1'b0;
    int         cyc = 0;
    int         last_accept_cyc = 0;
    int         abort_gap = -1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < 3; c++) begin
            m_full[c] = 1'b0;
            m_word[c] = '0;
            m_age[c]  = 0;
        end
        m_offer = 1'b0; m_ch = 0; m_flight = 1'b0; m_flight_t = 0;
        m_abort = 1'b0; m_lost = 0;
    endtask

    function automatic int rank(input int ch);
        if (ch == 1 && m_age[1] == AGE_MAX) return 4;
        if (ch == 2 && m_age[2] == AGE_MAX) return 3;
        if (ch == 0) return 2;
        if (ch == 2) return 1;
        return 0;
    endfunction

    task automatic modelStep(input bit cv, input logic [37:0] cd, input bit rv, input logic [25:0] rd,
                             input bit tv, input logic [31:0] td, input bit run, input bit rdy, input bit done);
        bit was_full[3];
        int rel;
        int best;
        was_full = m_full;
        rel = -1;
        best = -1;
        m_abort = 1'b0;
        if (m_offer) begin
            if (rdy) begin
                rel = m_ch;
                for (int c = 1; c < 3; c++) begin
                    if (c == m_ch) m_age[c] = 0;
                    else if (was_full[c] && m_age[c] < AGE_MAX) m_age[c]++;
                end
                m_offer = 1'b0; m_flight = 1'b1; m_flight_t = 0;
            end else if (!run) begin
                m_offer = 1'b0; m_abort = 1'b1;
            end
        end else if (m_flight) begin
            if (done) begin
                m_flight = 1'b0;
            end else begin
                m_flight_t++;
                if (!run || m_flight_t == TIMEOUT) begin
                    m_flight = 1'b0; m_abort = 1'b1;
                    if (m_lost < 255) m_lost++;
                end
            end
        end else if (run) begin
            for (int c = 0; c < 3; c++)
                if (was_full[c] && (best < 0 || rank(c) > rank(best))) best = c;
            if (best >= 0) begin
                m_offer = 1'b1; m_ch = best;
            end
        end
        if (rel >= 0) m_full[rel] = 1'b0;
        if (cv && !was_full[0]) begin m_full[0] = 1'b1; m_word[0] = cd; end
        if (rv && !was_full[1]) begin m_full[1] = 1'b1; m_word[1] = 38'(rd) << 12; end
        if (tv && !was_full[2]) begin m_full[2] = 1'b1; m_word[2] = 38'(td) << 6; end
    endtask

    task automatic checkAll();
        checkOutput("send_tvalid", 64'(bus.send_tvalid), 64'(m_offer));
        if (m_offer) begin
            checkOutput("send_tdata", 64'(bus.send_tdata), 64'(m_word[m_ch]));
            checkOutput("send_tuser", 64'(bus.send_tuser), 64'(m_ch + 1));
        end
        checkOutput("abort", 64'(abort), 64'(m_abort));
        checkOutput("lost_cnt", 64'(lost_cnt), 64'(m_lost));
        checkOutput("cmd_tready", 64'(bus.cmd_tready), 64'(!m_full[0]));
        checkOutput("rx_tready", 64'(bus.rx_tready), 64'(!m_full[1]));
        checkOutput("tx_tready", 64'(bus.tx_tready), 64'(!m_full[2]));
    endtask

    task automatic applyStimulus(input bit cv, input logic [37:0] cd, input bit rv, input logic [25:0] rd,
                                 input bit tv, input logic [31:0] td, input bit run, input bit rdy, input bit done);
        checkAll();
        if (abort) abort_gap = cyc - last_accept_cyc - 1;
        if (bus.send_tvalid && rdy) begin
            last_accept_cyc = cyc;
            if (log_en) obs_tags.push_back(bus.send_tuser);
        end
        bus.cmd_tvalid  = cv;  bus.cmd_tdata = cd;
        bus.rx_tvalid   = rv;  bus.rx_tdata  = rd;
        bus.tx_tvalid   = tv;  bus.tx_tdata  = td;
        running         = run;
        bus.send_tready = rdy;
        bus.send_tdone  = done;
        modelStep(cv, cd, rv, rd, tv, td, run, rdy, done);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idleCycles(input int n, input bit run, input bit rdy, input bit done);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, '0, 0, '0, run, rdy, done);
    endtask

    task automatic randomPhase(input int n, input int p_valid, input int p_drop, input int p_done, input int p_rdy);
        for (int i = 0; i < n; i++) begin
            logic [63:0] r64;
            r64 = {$urandom(), $urandom()};
            applyStimulus(int'($urandom_range(99)) < p_valid, r64[37:0],
                          int'($urandom_range(99)) < p_valid, 26'($urandom()),
                          int'($urandom_range(99)) < p_valid, $urandom(),
                          int'($urandom_range(99)) >= p_drop,
                          int'($urandom_range(99)) < p_rdy,
                          int'($urandom_range(99)) < p_done);
        end
    endtask

    function automatic int countTag(input logic [1:0] t);
        int n = 0;
        foreach (obs_tags[i]) if (obs_tags[i] == t) n++;
        return n;
    endfunction

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_send_tvalid"}, 64'(bus.send_tvalid), 64'd0);
        checkOutput({pfx, "_send_tdata"}, 64'(bus.send_tdata), 64'd0);
        checkOutput({pfx, "_send_tuser"}, 64'(bus.send_tuser), 64'd0);
        checkOutput({pfx, "_abort"}, 64'(abort), 64'd0);
        checkOutput({pfx, "_lost_cnt"}, 64'(lost_cnt), 64'd0);
        checkOutput({pfx, "_readies"}, 64'({bus.cmd_tready, bus.rx_tready, bus.tx_tready}), 64'h7);
    endtask

    initial begin
        rst_n = 1'b0;
        running = 1'b0;
        bus.cmd_tvalid = 0; bus.cmd_tdata = '0;
        bus.rx_tvalid = 0;  bus.rx_tdata = '0;
        bus.tx_tvalid = 0;  bus.tx_tdata = '0;
        bus.send_tready = 0; bus.send_tdone = 0;
        modelReset();
        #12;
        checkResetOutputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single command word");
        applyStimulus(1, 38'h2ADEADBEEF, 0, '0, 0, '0, 1, 1, 0);
        idleCycles(6, 1, 1, 1);

        $display("[TB] rx and tx loaded together");
        obs_tags.delete(); log_en = 1'b1;
        applyStimulus(0, '0, 1, 26'h3ABCDEF, 1, 32'h12345678, 1, 1, 1);
        idleCycles(10, 1, 1, 1);
        checkOutput("pair_count", 64'(obs_tags.size()), 64'd2);
        checkOutput("pair_first_tx", 64'(obs_tags.size() > 0 ? obs_tags[0] : 2'b00), 64'(2'b11));
        checkOutput("pair_second_rx", 64'(obs_tags.size() > 1 ? obs_tags[1] : 2'b00), 64'(2'b10));

        $display("[TB] tx streaming while rx waits");
        obs_tags.delete();
        for (int i = 0; i < 70; i++) applyStimulus(0, '0, 1, 26'($urandom()), 1, $urandom(), 1, 1, 1);
        idleCycles(12, 1, 1, 1);
        rx_pos.delete();
        foreach (obs_tags[i]) if (obs_tags[i] == 2'b10) rx_pos.push_back(i);
        checkOutput("rx_first_grant", 64'(rx_pos.size() > 0 ? rx_pos[0] : -1), 64'd8);
        checkOutput("rx_second_grant", 64'(rx_pos.size() > 1 ? rx_pos[1] : -1), 64'd17);

        $display("[TB] link drop during cmd offer");
        obs_tags.delete();
        applyStimulus(1, 38'h155AA55AA5, 0, '0, 0, '0, 1, 0, 0);
        idleCycles(1, 1, 0, 0);
        idleCycles(2, 0, 0, 0);
        idleCycles(6, 1, 1, 1);
        checkOutput("offer_drop_lost", 64'(lost_cnt), 64'd0);
        checkOutput("cmd_resent", 64'(countTag(2'b01)), 64'd1);

        $display("[TB] link drop during busy");
        applyStimulus(0, '0, 0, '0, 1, 32'hCAFEF00D, 1, 1, 0);
        idleCycles(2, 1, 1, 0);
        idleCycles(1, 0, 1, 0);
        checkOutput("busy_drop_abort", 64'(abort), 64'd1);
        checkOutput("busy_drop_lost", 64'(lost_cnt), 64'd1);
        idleCycles(3, 1, 1, 1);

        $display("[TB] withheld send_tdone");
        abort_gap = -1;
        applyStimulus(1, 38'h0123456789, 0, '0, 0, '0, 1, 1, 0);
        idleCycles(80, 1, 1, 0);
        checkOutput("timeout_gap", 64'(abort_gap), 64'(TIMEOUT));
        checkOutput("timeout_lost", 64'(lost_cnt), 64'd2);

        $display("[TB] reset during offer");
        applyStimulus(1, 38'h3FFFF00001, 0, '0, 0, '0, 1, 0, 0);
        idleCycles(1, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("midrst");
        bus.cmd_tvalid = 0; bus.rx_tvalid = 0; bus.tx_tvalid = 0;
        bus.send_tready = 0; bus.send_tdone = 0;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] randomized traffic");
        randomPhase(1500, 40, 2, 30, 60);
        randomPhase(800, 80, 0, 2, 90);
        randomPhase(1500, 60, 5, 50, 50);

        $display("[TB] lost counter saturation");
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) applyStimulus(0, '0, 0, '0, 1, $urandom(), k != 3, 1, 0);
        end
        idleCycles(2, 1, 1, 1);
        checkOutput("lost_saturated", 64'(lost_cnt), 64'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
